// File: rtl/xnor_match_pipe_if.sv
// rtl/xnor_match_pipe_if.sv - operand/result stream bundle for xnor_match_pipe
//
// Carries the input operand stream (in_*, in_ready) and the output result
// stream (out_*, out_ready). The slave modport is the pipeline side; the
// master modport is the source/consumer side.
interface xnor_match_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [CNT_W-1:0] out_cnt;
    logic             out_all;
    logic             out_last;
    logic [ACC_W-1:0] out_frame_cnt;
    logic             out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_y, out_cnt, out_all, out_last,
               out_frame_cnt, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_cnt, out_all, out_last,
               out_frame_cnt, out_sat
    );
endinterface

// File: rtl/xnor_match_pipe.sv
// rtl/xnor_match_pipe.sv - registered bitwise-op stage with popcount and frame accumulator
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - xnor_match_pipe_if.slave: operand stream in, result stream out
// One register stage; in_ready = !out_valid || out_ready (no skid buffer).
module xnor_match_pipe #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xnor_match_pipe_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_q, all_d;
    logic             last_q, last_d;
    logic [ACC_W-1:0] frame_q, frame_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        res = '0;
        case (bus.in_op)
            2'b00:   res = ~(bus.in_a ^ bus.in_b);
            2'b01:   res = bus.in_a ^ bus.in_b;
            2'b10:   res = bus.in_a & bus.in_b;
            default: res = bus.in_a | bus.in_b;
        endcase
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(res[i]);
        end
    end

    // One extra bit catches the carry out; any carry clamps to all ones.
    assign sum     = {1'b0, acc_q} + (ACC_W + 1)'(cnt);
    assign sum_ovf = sum[ACC_W];
    assign sum_sat = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        all_d   = all_q;
        last_d  = last_q;
        frame_d = frame_q;
        sat_d   = sat_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (accept) begin
            valid_d = 1'b1;
            y_d     = res;
            cnt_d   = cnt;
            all_d   = &res;
            last_d  = bus.in_last;
            if (bus.in_last) begin
                frame_d = sum_sat;
                sat_d   = ovf_q | sum_ovf;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                acc_d   = sum_sat;
                ovf_d   = ovf_q | sum_ovf;
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
            all_q   <= 1'b0;
            last_q  <= 1'b0;
            frame_q <= '0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            all_q   <= all_d;
            last_q  <= last_d;
            frame_q <= frame_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_y         = y_q;
    assign bus.out_cnt       = cnt_q;
    assign bus.out_all       = all_q;
    assign bus.out_last      = last_q;
    assign bus.out_frame_cnt = frame_q;
    assign bus.out_sat       = sat_q;
endmodule

// File: tb/tb_xnor_match_pipe.sv
// tb/tb_xnor_match_pipe.sv - directed bench for xnor_match_pipe
module tb_xnor_match_pipe;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    xnor_match_pipe_if #(.WIDTH(1), .ACC_W(16)) b1 ();
    xnor_match_pipe_if #(.WIDTH(8), .ACC_W(16)) b8 ();
    xnor_match_pipe_if #(.WIDTH(8), .ACC_W(4))  bs ();

    xnor_match_pipe #(.WIDTH(1), .ACC_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    xnor_match_pipe #(.WIDTH(8), .ACC_W(16)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    xnor_match_pipe #(.WIDTH(8), .ACC_W(4))  us (.clk(clk), .rst_n(rst_n), .bus(bs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic last);
        b8.in_valid = 1'b1;
        b8.in_a     = a;
        b8.in_b     = b;
        b8.in_op    = op;
        b8.in_last  = last;
    endtask

    task automatic drives(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic last);
        bs.in_valid = 1'b1;
        bs.in_a     = a;
        bs.in_b     = b;
        bs.in_op    = op;
        bs.in_last  = last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (b8.out_valid !== 1'b0 || b8.out_y !== 8'h00 || b8.out_cnt !== 4'd0 ||
            b8.out_all !== 1'b0 || b8.out_last !== 1'b0 || b8.out_frame_cnt !== 16'd0 ||
            b8.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b y=%h cnt=%0d all=%b last=%b fc=%0d sat=%b, want all zero",
                     b8.out_valid, b8.out_y, b8.out_cnt, b8.out_all, b8.out_last,
                     b8.out_frame_cnt, b8.out_sat);
        end
        total++;
        if (b8.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", b8.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic exp_y [4];
        exp_y = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            b1.in_valid = 1'b1;
            b1.in_a     = i[1];
            b1.in_b     = i[0];
            b1.in_op    = 2'b00;
            b1.in_last  = 1'b1;
            step();
            total++;
            if (b1.out_valid !== 1'b1 || b1.out_y !== exp_y[i]) begin
                bad++;
                $display("FAIL truth_%0d: got v=%b y=%b want v=1 y=%b",
                         i, b1.out_valid, b1.out_y, exp_y[i]);
            end
        end
        b1.in_valid = 1'b0;
        step();
    endtask

    task automatic test_xnor8();
        drive8(8'hF0, 8'hF0, 2'b00, 1'b1);
        step();
        total++;
        if (b8.out_y !== 8'hFF || b8.out_cnt !== 4'd8 || b8.out_all !== 1'b1) begin
            bad++;
            $display("FAIL xnor_equal: got y=%h cnt=%0d all=%b want y=ff cnt=8 all=1",
                     b8.out_y, b8.out_cnt, b8.out_all);
        end
        drive8(8'hA5, 8'h5A, 2'b00, 1'b1);
        step();
        total++;
        if (b8.out_y !== 8'h00 || b8.out_cnt !== 4'd0 || b8.out_all !== 1'b0) begin
            bad++;
            $display("FAIL xnor_diff: got y=%h cnt=%0d all=%b want y=00 cnt=0 all=0",
                     b8.out_y, b8.out_cnt, b8.out_all);
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_ops();
        logic [1:0] ops   [3];
        logic [7:0] exp_y [3];
        logic [3:0] exp_c [3];
        ops   = '{2'b01, 2'b10, 2'b11};
        exp_y = '{8'h66, 8'h88, 8'hEE};
        exp_c = '{4'd4, 4'd2, 4'd6};
        for (int i = 0; i < 3; i++) begin
            drive8(8'hCC, 8'hAA, ops[i], 1'b1);
            step();
            total++;
            if (b8.out_y !== exp_y[i] || b8.out_cnt !== exp_c[i] || b8.out_all !== 1'b0) begin
                bad++;
                $display("FAIL op_%0d: got y=%h cnt=%0d all=%b want y=%h cnt=%0d all=0",
                         ops[i], b8.out_y, b8.out_cnt, b8.out_all, exp_y[i], exp_c[i]);
            end
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_frame();
        drive8(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        drive8(8'hF0, 8'h00, 2'b00, 1'b0);
        step();
        total++;
        if (b8.out_y !== 8'h0F || b8.out_last !== 1'b0) begin
            bad++;
            $display("FAIL frame_mid: got y=%h last=%b want y=0f last=0", b8.out_y, b8.out_last);
        end
        drive8(8'hFE, 8'h00, 2'b00, 1'b1);
        step();
        total++;
        if (b8.out_y !== 8'h01 || b8.out_last !== 1'b1 || b8.out_frame_cnt !== 16'd13 ||
            b8.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL frame_3beat: got y=%h last=%b fc=%0d sat=%b want y=01 last=1 fc=13 sat=0",
                     b8.out_y, b8.out_last, b8.out_frame_cnt, b8.out_sat);
        end
        drive8(8'hFC, 8'h00, 2'b00, 1'b1);
        step();
        total++;
        if (b8.out_y !== 8'h03 || b8.out_frame_cnt !== 16'd2 || b8.out_sat !== 1'b0) begin
            bad++;
            $display("FAIL frame_single: got y=%h fc=%0d sat=%b want y=03 fc=2 sat=0",
                     b8.out_y, b8.out_frame_cnt, b8.out_sat);
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        b8.out_ready = 1'b0;
        drive8(8'h01, 8'h00, 2'b11, 1'b1);
        step();
        drive8(8'h03, 8'h00, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1 || b8.out_y !== 8'h01 ||
                b8.out_cnt !== 4'd1) begin
                bad++;
                $display("FAIL stall_%0d: got rdy=%b v=%b y=%h cnt=%0d want rdy=0 v=1 y=01 cnt=1",
                         i, b8.in_ready, b8.out_valid, b8.out_y, b8.out_cnt);
            end
            step();
        end
        b8.out_ready = 1'b1;
        #1;
        total++;
        if (b8.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b want 1", b8.in_ready);
        end
        step();
        b8.in_valid = 1'b0;
        total++;
        if (b8.out_valid !== 1'b1 || b8.out_y !== 8'h03) begin
            bad++;
            $display("FAIL release_beat: got v=%b y=%h want v=1 y=03", b8.out_valid, b8.out_y);
        end
        step();
        total++;
        if (b8.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got v=%b want 0", b8.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y [4];
        exp_y = '{8'h11, 8'h22, 8'h44, 8'h88};
        for (int i = 0; i < 4; i++) begin
            drive8(exp_y[i], 8'h00, 2'b11, 1'b1);
            step();
            total++;
            if (b8.out_valid !== 1'b1 || b8.out_y !== exp_y[i] || b8.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: got v=%b y=%h rdy=%b want v=1 y=%h rdy=1",
                         i, b8.out_valid, b8.out_y, b8.in_ready, exp_y[i]);
            end
        end
        b8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_sat_reset();
        drives(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        drives(8'h00, 8'h00, 2'b00, 1'b1);
        step();
        total++;
        if (bs.out_frame_cnt !== 4'd15 || bs.out_sat !== 1'b1 || bs.out_last !== 1'b1) begin
            bad++;
            $display("FAIL saturate: got fc=%0d sat=%b last=%b want fc=15 sat=1 last=1",
                     bs.out_frame_cnt, bs.out_sat, bs.out_last);
        end
        drives(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        bs.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bs.out_valid !== 1'b0 || bs.out_y !== 8'h00 || bs.out_cnt !== 4'd0 ||
            bs.out_all !== 1'b0 || bs.out_last !== 1'b0 || bs.out_frame_cnt !== 4'd0 ||
            bs.out_sat !== 1'b0 || bs.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got v=%b y=%h cnt=%0d all=%b last=%b fc=%0d sat=%b rdy=%b want zeros rdy=1",
                     bs.out_valid, bs.out_y, bs.out_cnt, bs.out_all, bs.out_last,
                     bs.out_frame_cnt, bs.out_sat, bs.in_ready);
        end
        step();
        rst_n = 1'b1;
        drives(8'hFC, 8'h00, 2'b00, 1'b1);
        step();
        total++;
        if (bs.out_frame_cnt !== 4'd2 || bs.out_sat !== 1'b0 || bs.out_y !== 8'h03) begin
            bad++;
            $display("FAIL post_reset_frame: got y=%h fc=%0d sat=%b want y=03 fc=2 sat=0",
                     bs.out_y, bs.out_frame_cnt, bs.out_sat);
        end
        bs.in_valid = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        {b1.in_valid, b1.in_a, b1.in_b, b1.in_op, b1.in_last} = '0;
        {b8.in_valid, b8.in_a, b8.in_b, b8.in_op, b8.in_last} = '0;
        {bs.in_valid, bs.in_a, bs.in_b, bs.in_op, bs.in_last} = '0;
        b1.out_ready = 1'b1;
        b8.out_ready = 1'b1;
        bs.out_ready = 1'b1;
        test_reset();
        test_truth_table();
        test_xnor8();
        test_ops();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_sat_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
